// File: rtl/ps2_key_sequencer.sv
// Polls the ps2_if receive FIFO and folds PS/2 set-2 E0/F0 prefix streams into single key events.
// Optional build macro: PS2_KEY_REPEAT_FILTER_EN suppresses typematic repeats of the last make.
module ps2_key_sequencer #(
  parameter int POLL_DIV = 64,
  parameter int FIFO_LAT = 1,
  parameter int TIMEOUT  = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       proto_err
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int WW = (FIFO_LAT > 1) ? $clog2(FIFO_LAT) : 1;
  localparam int TW = (TIMEOUT > 1)  ? $clog2(TIMEOUT)  : 1;

  localparam logic [1:0] S_POLL = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DEC  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wait_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    byte_r;
  logic          ext_f;
  logic          brk_f;
  logic          poll_hit;
  logic          is_e0;
  logic          is_f0;
  logic          is_bad;
  logic          suppress;

  assign poll_hit = (poll_cnt == PW'(POLL_DIV - 1));
  assign fifo_rd  = (state == S_POP);
  assign is_e0    = (byte_r == 8'hE0);
  assign is_f0    = (byte_r == 8'hF0);
  assign is_bad   = (byte_r == 8'hE1) || (byte_r == 8'h00) || (byte_r == 8'hFF);

`ifdef PS2_KEY_REPEAT_FILTER_EN
  logic       lm_vld;
  logic       lm_ext;
  logic [7:0] lm_code;
  logic       lm_match;

  assign lm_match = lm_vld && (lm_ext == ext_f) && (lm_code == byte_r);

  always_comb begin
    suppress = 1'b0;
    if (!brk_f && lm_match) suppress = 1'b1;
  end

  // Emitted makes arm the filter; a matching break disarms it so the next press gets through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lm_vld  <= 1'b0;
      lm_ext  <= 1'b0;
      lm_code <= 8'h00;
    end else if (state == S_DEC && !is_e0 && !is_f0 && !is_bad) begin
      if (brk_f) begin
        if (lm_match) lm_vld <= 1'b0;
      end else if (!lm_match) begin
        lm_vld  <= 1'b1;
        lm_ext  <= ext_f;
        lm_code <= byte_r;
      end
    end
  end
`else
  always_comb begin
    suppress = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_hit) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_POLL;
      wait_cnt  <= '0;
      tmo_cnt   <= '0;
      byte_r    <= 8'h00;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      proto_err <= 1'b0;
      case (state)
        S_POLL: begin
          // A pop at the poll instant takes priority over an expiring prefix.
          if (poll_hit && !fifo_empty) begin
            state   <= S_POP;
            tmo_cnt <= '0;
          end else if (ext_f || brk_f) begin
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
              proto_err <= 1'b1;
              ext_f     <= 1'b0;
              brk_f     <= 1'b0;
              tmo_cnt   <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end else begin
            tmo_cnt <= '0;
          end
        end
        S_POP: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
          tmo_cnt  <= '0;
        end
        S_WAIT: begin
          if (wait_cnt == WW'(FIFO_LAT - 1)) begin
            byte_r <= fifo_data;
            state  <= S_DEC;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DEC: begin
          state <= S_POLL;
          if (is_e0 && !ext_f && !brk_f) begin
            ext_f <= 1'b1;
          end else if (is_f0 && !brk_f) begin
            brk_f <= 1'b1;
          end else if (!is_e0 && !is_f0 && !is_bad) begin
            if (!suppress) begin
              key_code  <= byte_r;
              key_ext   <= ext_f;
              key_break <= brk_f;
              key_valid <= 1'b1;
            end
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end else begin
            proto_err <= 1'b1;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
          end
        end
        default: state <= S_POLL;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer: FIFO model, event scoreboard and summary.
module tb_ps2_key_sequencer;

  localparam int POLL_DIV = 8;
  localparam int FIFO_LAT = 2;
  localparam int TIMEOUT  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       proto_err;

  ps2_key_sequencer #(.POLL_DIV(POLL_DIV), .FIFO_LAT(FIFO_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_valid(key_valid), .proto_err(proto_err)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data is only valid exactly FIFO_LAT cycles after the pop strobe.
  logic [7:0] fifo_q[$];
  logic [7:0] fifo_byte = 8'h00;
  logic [7:0] rd_pipe = 8'h00;
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[6:0], fifo_rd};
    if (fifo_rd && fifo_q.size() > 0) fifo_byte <= fifo_q.pop_front();
  end
  always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);
  always_comb fifo_data = rd_pipe[FIFO_LAT-1] ? fifo_byte : 8'h00;

  // scoreboard
  int n_total = 0;
  int n_bad = 0;
  int n_rd = 0;
  int n_err = 0;
  int rd_cyc = 0;
  int kv_cyc = 0;
  int err_cyc = 0;
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd) begin
        check("rd_nonempty", {31'd0, fifo_q.size() > 0}, 1);
        n_rd++;
        rd_cyc = cyc;
      end
      if (key_valid) begin
        check("kv_err_excl", {31'd0, proto_err}, 0);
        got_q.push_back({key_ext, key_break, key_code});
        kv_cyc = cyc;
      end
      if (proto_err) begin
        n_err++;
        err_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic push(input logic [7:0] b);
    @(negedge clk);
    fifo_q.push_back(b);
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask

  task automatic start_case();
    got_q.delete();
    exp_q.delete();
    n_rd = 0;
    n_err = 0;
  endtask

  task automatic settle();
    for (int i = 0; i < 2000 && fifo_q.size() != 0; i++) @(negedge clk);
    repeat (POLL_DIV + FIFO_LAT + 8) @(negedge clk);
    check("drained", {31'd0, fifo_empty}, 1);
  endtask

  task automatic compare_events(input string tag, input int exp_err);
    check({tag, "_nevt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_evt"}, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    check({tag, "_nerr"}, n_err, exp_err);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_fifo_rd", {31'd0, fifo_rd}, 0);
    check("rst_key_valid", {31'd0, key_valid}, 0);
    check("rst_proto_err", {31'd0, proto_err}, 0);
    check("rst_key_code", {24'd0, key_code}, 0);
    check("rst_key_flags", {30'd0, key_ext, key_break}, 0);
    rst = 1'b0;

    // single make
    start_case();
    push(8'h1C);
    settle();
    expect_evt(1'b0, 1'b0, 8'h1C);
    check("t1_pops", n_rd, 1);
    check("t1_latency", kv_cyc - rd_cyc, FIFO_LAT + 2);
    check("t1_held_code", {24'd0, key_code}, 32'h1C);
    compare_events("t1", 0);

    // break
    start_case();
    push(8'hF0); push(8'h1C);
    settle();
    expect_evt(1'b0, 1'b1, 8'h1C);
    check("t2_pops", n_rd, 2);
    compare_events("t2", 0);

    // extended break, then plain make
    start_case();
    push(8'hE0); push(8'hF0); push(8'h75); push(8'h74);
    settle();
    expect_evt(1'b1, 1'b1, 8'h75);
    expect_evt(1'b0, 1'b0, 8'h74);
    compare_events("t3", 0);

    // malformed prefixes then clean decode
    start_case();
    push(8'hF0); push(8'hE0); push(8'hE0); push(8'hE0); push(8'h1D);
    settle();
    expect_evt(1'b0, 1'b0, 8'h1D);
    check("t4_pops", n_rd, 5);
    compare_events("t4", 2);

    // prefix timeout
    start_case();
    push(8'hE0);
    settle();
    repeat (TIMEOUT + 50) @(negedge clk);
    check("t5_tmo_cnt", n_err, 1);
    check("t5_tmo_time", err_cyc - rd_cyc, FIFO_LAT + 2 + TIMEOUT);
    push(8'h6B);
    settle();
    expect_evt(1'b0, 1'b0, 8'h6B);
    check("t5_key_ext", {31'd0, key_ext}, 0);
    compare_events("t5", 1);

    // typematic repeats
    start_case();
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1C);
    settle();
    expect_evt(1'b0, 1'b0, 8'h1C);
`ifndef PS2_KEY_REPEAT_FILTER_EN
    expect_evt(1'b0, 1'b0, 8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C);
`endif
    expect_evt(1'b0, 1'b1, 8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C);
    compare_events("t6", 0);

    // reset with a pending E0 prefix
    start_case();
    push(8'hE0);
    for (int i = 0; i < 200 && n_rd == 0; i++) @(negedge clk);
    check("t7_pop_seen", n_rd, 1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (TIMEOUT * 2 + 50) @(negedge clk);
    compare_events("t7_quiet", 0);
    push(8'h1C);
    settle();
    expect_evt(1'b0, 1'b0, 8'h1C);
    compare_events("t7", 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
